ysyx_22050710_sram_arbiter: RTL and testbench

//  Shares one unified SRAM port between the core's inst-fetch master (if stage) and data master (ex/mem stages).

---
 rtl/ysyx_22050710_sram_arbiter_pkg.sv | 14 +
 rtl/ysyx_22050710_sram_arbiter.sv | 114 +++++++++++
 tb/tb_ysyx_22050710_sram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Shared encodings for the unified SRAM port arbiter: FSM state and transaction owner.
package ysyx_22050710_sram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Shares one SRAM port between the fetch and data masters: one outstanding transaction,
// data has priority, and a starvation counter forces a fetch grant after STARVE_MAX data wins.
module ysyx_22050710_sram_arbiter
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_DATA_WD  = 64,
  parameter int SRAM_WMASK_WD = 8,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_inst_req,
  input  logic [SRAM_ADDR_WD-1:0]  i_inst_addr,
  output logic                     o_inst_gnt,
  output logic                     o_inst_rvalid,
  output logic [SRAM_DATA_WD-1:0]  o_inst_rdata,
  input  logic                     i_data_req,
  input  logic                     i_data_wen,
  input  logic [SRAM_ADDR_WD-1:0]  i_data_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_data_wmask,
  input  logic [SRAM_DATA_WD-1:0]  i_data_wdata,
  output logic                     o_data_gnt,
  output logic                     o_data_rvalid,
  output logic [SRAM_DATA_WD-1:0]  o_data_rdata,
  output logic                     o_mem_req,
  output logic                     o_mem_wen,
  output logic [SRAM_ADDR_WD-1:0]  o_mem_addr,
  output logic [SRAM_WMASK_WD-1:0] o_mem_wmask,
  output logic [SRAM_DATA_WD-1:0]  o_mem_wdata,
  input  logic                     i_mem_gnt,
  input  logic                     i_mem_rvalid,
  input  logic [SRAM_DATA_WD-1:0]  i_mem_rdata
);

  localparam int CNT_WD = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(STARVE_MAX);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic [CNT_WD-1:0] r_starve_cnt;
  // Write/read kind of the outstanding data access; the master drops i_data_wen after its grant.
  logic              r_data_wen;

  logic w_idle;
  logic w_pick_data;
  logic w_pick_inst;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_pick_data = i_data_req && !(i_inst_req && (r_starve_cnt == CNT_MAX));
  assign w_pick_inst = i_inst_req && !w_pick_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_INST;
      r_starve_cnt <= '0;
      r_data_wen   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (!i_inst_req) begin
        r_starve_cnt <= '0;
      end else if (i_mem_gnt && w_pick_inst) begin
        r_starve_cnt <= '0;
      end else if (i_mem_gnt && w_pick_data && (r_starve_cnt != CNT_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (i_mem_gnt && (w_pick_data || w_pick_inst)) begin
        r_state    <= ST_WAIT;
        r_owner    <= w_pick_data ? OWNER_DATA : OWNER_INST;
        r_data_wen <= w_pick_data && i_data_wen;
      end
    end else begin
      if (i_mem_rvalid) begin
        r_state <= ST_IDLE;
      end
    end
  end

  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_addr    = '0;
    o_mem_wmask   = '0;
    o_mem_wdata   = '0;
    o_inst_gnt    = 1'b0;
    o_data_gnt    = 1'b0;
    o_inst_rvalid = 1'b0;
    o_inst_rdata  = '0;
    o_data_rvalid = 1'b0;
    o_data_rdata  = '0;
    if (w_idle) begin
      o_mem_req = i_inst_req || i_data_req;
      if (w_pick_data) begin
        o_mem_wen   = i_data_wen;
        o_mem_addr  = i_data_addr;
        o_mem_wmask = i_data_wmask;
        o_mem_wdata = i_data_wdata;
        o_data_gnt  = i_mem_gnt;
      end else if (w_pick_inst) begin
        o_mem_addr = i_inst_addr;
        o_inst_gnt = i_mem_gnt;
      end
    end else if (i_mem_rvalid) begin
      if (r_owner == OWNER_DATA) begin
        o_data_rvalid = 1'b1;
        o_data_rdata  = r_data_wen ? '0 : i_mem_rdata;
      end else begin
        o_inst_rvalid = 1'b1;
        o_inst_rdata  = i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Self-checking bench for the SRAM arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the priority and starvation rules.
module tb_ysyx_22050710_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_gnt, inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0, data_wen = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [MW-1:0] data_wmask = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt, data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          mem_req, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  ysyx_22050710_sram_arbiter #(
    .SRAM_ADDR_WD (AW),
    .SRAM_DATA_WD (DW),
    .SRAM_WMASK_WD(MW),
    .STARVE_MAX   (SMAX)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr),
    .o_inst_gnt(inst_gnt), .o_inst_rvalid(inst_rvalid), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_wen(data_wen), .i_data_addr(data_addr),
    .i_data_wmask(data_wmask), .i_data_wdata(data_wdata),
    .o_data_gnt(data_gnt), .o_data_rvalid(data_rvalid), .o_data_rdata(data_rdata),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wmask(mem_wmask), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [237:0] all_out;
  assign all_out = {inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
                    mem_req, mem_wen, mem_addr, mem_wmask, mem_wdata};

  // Inputs change 1 time unit after the rising edge; checks happen one unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    step(); rst = 1'b0; #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D; mem_gnt = 1'b1; #1;
    checks++;
    if ({inst_rvalid, data_rvalid, inst_gnt, data_gnt} !== 4'b0 || inst_rdata !== '0 || data_rdata !== '0) begin
      failures++;
      $display("FAIL idle_rvalid_ignored got=%b exp=0000", {inst_rvalid, data_rvalid, inst_gnt, data_gnt});
    end
    step(); mem_rvalid = 1'b0; mem_gnt = 1'b0;
  endtask

  task automatic test_inst_only();
    inst_req = 1'b1; inst_addr = 32'h8000_0000; mem_gnt = 1'b1; #1;
    checks++;
    if ({mem_req, inst_gnt, data_gnt, mem_wen} !== 4'b1100 || mem_addr !== 32'h8000_0000 || mem_wdata !== '0 || mem_wmask !== '0) begin
      failures++;
      $display("FAIL inst_gnt got=%b addr=%h exp=1100 addr=80000000", {mem_req, inst_gnt, data_gnt, mem_wen}, mem_addr);
    end
    step(); inst_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234; #1;
    checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 64'h1234 || data_rvalid !== 1'b0) begin
      failures++; $display("FAIL inst_rvalid got=%b/%h exp=1/1234", inst_rvalid, inst_rdata);
    end
    step(); mem_rvalid = 1'b0; #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL inst_after got=%h exp=0", all_out); end
  endtask

  task automatic test_priority();
    inst_req = 1'b1; inst_addr = 32'h8000_0040;
    data_req = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_1000; mem_gnt = 1'b1; #1;
    checks++;
    if ({data_gnt, inst_gnt} !== 2'b10 || mem_addr !== 32'h8000_1000) begin
      failures++; $display("FAIL prio_data_first got=%b addr=%h exp=10 addr=80001000", {data_gnt, inst_gnt}, mem_addr);
    end
    step(); data_req = 1'b0; #1;
    checks++;
    if ({mem_req, inst_gnt, data_gnt} !== 3'b000) begin
      failures++; $display("FAIL prio_wait_quiet got=%b exp=000", {mem_req, inst_gnt, data_gnt});
    end
    mem_rvalid = 1'b1; mem_rdata = 64'hA5A5_0000_1111_2222; #1;
    checks++;
    if (data_rvalid !== 1'b1 || data_rdata !== 64'hA5A5_0000_1111_2222 || inst_rvalid !== 1'b0) begin
      failures++; $display("FAIL prio_data_resp got=%b/%h exp=1/a5a5000011112222", data_rvalid, data_rdata);
    end
    step(); mem_rvalid = 1'b0; #1;
    checks++;
    if ({inst_gnt, data_gnt} !== 2'b10 || mem_addr !== 32'h8000_0040) begin
      failures++; $display("FAIL prio_inst_next got=%b addr=%h exp=10 addr=80000040", {inst_gnt, data_gnt}, mem_addr);
    end
    step(); inst_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77; #1;
    checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 64'h77) begin
      failures++; $display("FAIL prio_inst_resp got=%b/%h exp=1/77", inst_rvalid, inst_rdata);
    end
    step(); mem_rvalid = 1'b0;
  endtask

  task automatic test_starvation();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h8000_0100;
    data_req = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_2000;
    for (int k = 0; k < 2 * SMAX + 2; k++) begin
      logic exp_inst;
      exp_inst = (k == SMAX) || (k == 2 * SMAX + 1);
      mem_gnt = 1'b1; #1;
      checks++;
      if ({inst_gnt, data_gnt} !== {exp_inst, !exp_inst}) begin
        failures++; $display("FAIL starve_grant_%0d got=%b exp=%b", k, {inst_gnt, data_gnt}, {exp_inst, !exp_inst});
      end
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'(k);
      step(); mem_rvalid = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic test_write_delay();
    data_req = 1'b1; data_wen = 1'b1; data_wmask = 8'hFF;
    data_addr = 32'h8000_3008; data_wdata = 64'h0123_4567_89AB_CDEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({mem_req, mem_wen, data_gnt} !== 3'b110 || mem_addr !== 32'h8000_3008 ||
          mem_wmask !== 8'hFF || mem_wdata !== 64'h0123_4567_89AB_CDEF) begin
        failures++;
        $display("FAIL wr_hold_%0d got=%b %h %h %h exp=110 80003008 ff 0123456789abcdef",
                 c, {mem_req, mem_wen, data_gnt}, mem_addr, mem_wmask, mem_wdata);
      end
      step();
    end
    mem_gnt = 1'b1; #1;
    checks++; if (data_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", data_gnt); end
    step(); data_req = 1'b0; data_wen = 1'b0; mem_gnt = 1'b0; #1;
    checks++;
    if ({data_rvalid, inst_rvalid, mem_req} !== 3'b000) begin
      failures++; $display("FAIL wr_wait got=%b exp=000", {data_rvalid, inst_rvalid, mem_req});
    end
    step(); mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    checks++;
    if (data_rvalid !== 1'b1 || data_rdata !== '0) begin
      failures++; $display("FAIL wr_ack got=%b/%h exp=1/0", data_rvalid, data_rdata);
    end
    step(); mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_wait();
    inst_req = 1'b1; inst_addr = 32'h8000_0200; mem_gnt = 1'b1;
    step(); inst_req = 1'b0; mem_gnt = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h55; #1;
    checks++;
    if ({inst_rvalid, data_rvalid} !== 2'b00) begin
      failures++; $display("FAIL rst_wait_drop got=%b exp=00", {inst_rvalid, data_rvalid});
    end
    step(); mem_rvalid = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h8000_0204; mem_gnt = 1'b1; #1;
    checks++;
    if (inst_gnt !== 1'b1 || mem_addr !== 32'h8000_0204) begin
      failures++; $display("FAIL rst_wait_regnt got=%b addr=%h exp=1 addr=80000204", inst_gnt, mem_addr);
    end
    step(); inst_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h66; #1;
    checks++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 64'h66) begin
      failures++; $display("FAIL rst_wait_resp got=%b/%h exp=1/66", inst_rvalid, inst_rdata);
    end
    step(); mem_rvalid = 1'b0;
  endtask

  // Transaction-level model: each loop pass is one arbitration round plus its response.
  task automatic test_random();
    int consec_data;
    logic win_data, exp_wen;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, rd;
    logic [MW-1:0] exp_wmask;
    do_reset();
    consec_data = 0;
    for (int t = 0; t < 300; t++) begin
      if (!inst_req && ($urandom_range(0, 1) == 1)) begin
        inst_req = 1'b1; inst_addr = $urandom;
      end
      if (!data_req && ($urandom_range(0, 2) != 0)) begin
        data_req = 1'b1; data_wen = 1'($urandom); data_addr = $urandom;
        data_wmask = 8'($urandom); data_wdata = {$urandom, $urandom};
      end
      if (!inst_req && !data_req) begin
        mem_gnt = 1'($urandom); #1;
        checks++;
        if ({mem_req, inst_gnt, data_gnt} !== 3'b000) begin
          failures++; $display("FAIL rnd_idle_%0d got=%b exp=000", t, {mem_req, inst_gnt, data_gnt});
        end
        consec_data = 0;
        step(); mem_gnt = 1'b0;
        continue;
      end
      win_data  = data_req && !(inst_req && consec_data >= SMAX);
      exp_wen   = win_data ? data_wen : 1'b0;
      exp_addr  = win_data ? data_addr : inst_addr;
      exp_wmask = win_data ? data_wmask : '0;
      exp_wdata = win_data ? data_wdata : '0;
      for (int d = int'($urandom_range(0, 3)); d >= 0; d--) begin
        mem_gnt = (d == 0); #1;
        checks++;
        if ({mem_req, mem_wen, data_gnt, inst_gnt} !== {1'b1, exp_wen, win_data && d == 0, !win_data && d == 0} ||
            mem_addr !== exp_addr || mem_wmask !== exp_wmask || mem_wdata !== exp_wdata) begin
          failures++;
          $display("FAIL rnd_arb_%0d got=%b %h %h %h exp=%b %h %h %h", t,
                   {mem_req, mem_wen, data_gnt, inst_gnt}, mem_addr, mem_wmask, mem_wdata,
                   {1'b1, exp_wen, win_data && d == 0, !win_data && d == 0}, exp_addr, exp_wmask, exp_wdata);
        end
        step();
      end
      mem_gnt = 1'b0;
      if (!inst_req || !win_data) consec_data = 0;
      else if (consec_data < SMAX) consec_data++;
      if (win_data) data_req = 1'b0; else inst_req = 1'b0;
      for (int r = int'($urandom_range(1, 3)); r >= 1; r--) begin
        rd = {$urandom, $urandom};
        mem_rvalid = (r == 1); mem_rdata = rd; mem_gnt = 1'($urandom); #1;
        checks++;
        if ({mem_req, inst_gnt, data_gnt} !== 3'b000 ||
            {data_rvalid, inst_rvalid} !== {win_data && r == 1, !win_data && r == 1} ||
            data_rdata !== ((win_data && r == 1 && !exp_wen) ? rd : '0) ||
            inst_rdata !== ((!win_data && r == 1) ? rd : '0)) begin
          failures++;
          $display("FAIL rnd_resp_%0d got=%b %b %h %h exp_data_owner=%b wen=%b last=%0d", t,
                   {mem_req, inst_gnt, data_gnt}, {data_rvalid, inst_rvalid}, data_rdata, inst_rdata,
                   win_data, exp_wen, (r == 1));
        end
        step();
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inst_only();
    test_priority();
    test_starvation();
    test_write_delay();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
